mem_cmd_responder: RTL and testbench

Memory-side responder for the shared command bus. Accepts 32-bit command words issued by accelerator control FSMs, decodes read (opcode 01) and write (opcode 10) commands addressed to its bus ID, and moves a fixed-size byte block between an on-chip memory port and the byte-stream data bus. When a transfer completes it pulses the ACK `{1'b1, MY_ID}`, which the initiating FSM waits for.

---
 rtl/mem_cmd_responder.sv | 160 ++++++++++++++++
 tb/tb_mem_cmd_responder.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_cmd_responder.sv
// Memory-side command responder: decodes bus read/write commands and moves
// a fixed-size byte block between the memory port and the byte streams.
module mem_cmd_responder #(
  parameter int         ADDRW       = 24,
  parameter logic [1:0] MY_ID       = 2'b00,
  parameter int         BLOCK_BYTES = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  input  logic [ADDRW+7:0] cmd_data,
  output logic             cmd_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic [ADDRW-1:0] mem_addr,
  output logic [7:0]       mem_wdata,
  input  logic             mem_ready,
  input  logic             mem_rvalid,
  input  logic [7:0]       mem_rdata,
  output logic             tx_valid,
  output logic [7:0]       tx_data,
  input  logic             tx_ready,
  input  logic             rx_valid,
  input  logic [7:0]       rx_data,
  output logic             rx_ready,
  output logic [2:0]       ack_out,
  output logic             busy
);

  localparam int CW = $clog2(BLOCK_BYTES);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RD_REQ  = 3'd1,
    S_RD_WAIT = 3'd2,
    S_RD_SEND = 3'd3,
    S_WR_RECV = 3'd4,
    S_WR_REQ  = 3'd5,
    S_ACK     = 3'd6
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [ADDRW-1:0] base_q, base_d;
  logic [7:0]       byte_q, byte_d;

  logic [1:0]       cmd_op, cmd_src, cmd_dst, cmd_rsv;
  logic [ADDRW-1:0] cmd_addr;
  logic             is_rd, is_wr, last;
  logic [ADDRW-1:0] cur_addr;

  assign cmd_op   = cmd_data[1:0];
  assign cmd_src  = cmd_data[3:2];
  assign cmd_dst  = cmd_data[5:4];
  assign cmd_rsv  = cmd_data[7:6];
  assign cmd_addr = cmd_data[ADDRW+7:8];

  // Reserved bits must be zero for a command to be ours
  assign is_rd = (cmd_op == 2'b01) && (cmd_src == MY_ID) && (cmd_rsv == 2'b00);
  assign is_wr = (cmd_op == 2'b10) && (cmd_dst == MY_ID) && (cmd_rsv == 2'b00);

  assign last     = (cnt_q == CW'(BLOCK_BYTES - 1));
  assign cur_addr = base_q + ADDRW'(cnt_q);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      base_q  <= '0;
      byte_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      base_q  <= base_d;
      byte_q  <= byte_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    base_d    = base_q;
    byte_d    = byte_q;
    cmd_ready = 1'b0;
    busy      = 1'b1;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    tx_valid  = 1'b0;
    tx_data   = '0;
    rx_ready  = 1'b0;
    ack_out   = '0;
    case (state_q)
      S_IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
        if (cmd_valid && is_rd) begin
          base_d  = cmd_addr;
          cnt_d   = '0;
          state_d = S_RD_REQ;
        end else if (cmd_valid && is_wr) begin
          base_d  = cmd_addr;
          cnt_d   = '0;
          state_d = S_WR_RECV;
        end
      end
      S_RD_REQ: begin
        mem_req  = 1'b1;
        mem_addr = cur_addr;
        if (mem_ready) state_d = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        if (mem_rvalid) begin
          byte_d  = mem_rdata;
          state_d = S_RD_SEND;
        end
      end
      S_RD_SEND: begin
        tx_valid = 1'b1;
        tx_data  = byte_q;
        if (tx_ready) begin
          if (last) begin
            state_d = S_ACK;
          end else begin
            cnt_d   = cnt_q + CW'(1);
            state_d = S_RD_REQ;
          end
        end
      end
      S_WR_RECV: begin
        rx_ready = 1'b1;
        if (rx_valid) begin
          byte_d  = rx_data;
          state_d = S_WR_REQ;
        end
      end
      S_WR_REQ: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = cur_addr;
        mem_wdata = byte_q;
        if (mem_ready) begin
          if (last) begin
            state_d = S_ACK;
          end else begin
            cnt_d   = cnt_q + CW'(1);
            state_d = S_WR_RECV;
          end
        end
      end
      S_ACK: begin
        ack_out = {1'b1, MY_ID};
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_cmd_responder.sv
// Scoreboard bench for mem_cmd_responder: block-level reference model feeds
// expectation queues, a negedge monitor plays the peers and checks.
module tb_mem_cmd_responder;

  localparam int         AW = 24;
  localparam int         BB = 32;
  localparam logic [1:0] ID = 2'b00;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cmd_valid = 1'b0;
  logic [AW+7:0] cmd_data = '0;
  logic          cmd_ready;
  logic          mem_req, mem_we;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_wdata;
  logic          mem_ready = 1'b0;
  logic          mem_rvalid = 1'b0;
  logic [7:0]    mem_rdata = '0;
  logic          tx_valid;
  logic [7:0]    tx_data;
  logic          tx_ready = 1'b0;
  logic          rx_valid = 1'b0;
  logic [7:0]    rx_data = '0;
  logic          rx_ready;
  logic [2:0]    ack_out;
  logic          busy;

  always #5 clk = ~clk;

  mem_cmd_responder #(.ADDRW(AW), .MY_ID(ID), .BLOCK_BYTES(BB)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_data(cmd_data), .cmd_ready(cmd_ready),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ready(mem_ready),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
    .ack_out(ack_out), .busy(busy)
  );

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [7:0]    data;
  } macc_t;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] ref_mem  [logic [AW-1:0]];
  logic [7:0] phys_mem [logic [AW-1:0]];
  macc_t      exp_mem [$];
  logic [7:0] exp_tx  [$];
  logic [7:0] rx_q    [$];
  int         exp_ack = 0;

  int mem_lat = 0, rd_lat = 0, tx_pct = 100, tx_stall = 0;
  bit rx_gap = 0, lat_chk = 0;
  int lat_exp = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] ref_rd(logic [AW-1:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : a[7:0];
  endfunction

  function automatic logic [7:0] phys_rd(logic [AW-1:0] a);
    return phys_mem.exists(a) ? phys_mem[a] : a[7:0];
  endfunction

  // Peer models and scoreboard monitor share one negedge process
  int            cyc = 0, acc_cyc = 0, req_wait = 0, pend_dly = 0;
  bit            pend_rd = 0, gap_ph = 0, tx_stalled = 0;
  logic [AW-1:0] pend_addr;
  logic [7:0]    last_tx;
  macc_t         e;

  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      mem_ready = 0; mem_rvalid = 0; mem_rdata = 0;
      tx_ready = 0; rx_valid = 0; rx_data = 0;
      pend_rd = 0; req_wait = 0; tx_stalled = 0;
    end else begin
      mem_rvalid = 0;
      mem_rdata  = 0;
      if (pend_rd) begin
        if (pend_dly == 0) begin
          mem_rvalid = 1;
          mem_rdata  = phys_rd(pend_addr);
          pend_rd    = 0;
        end else pend_dly--;
      end
      mem_ready = mem_req && (req_wait >= mem_lat);
      if (tx_valid && tx_stall > 0) begin
        tx_ready = 0;
        tx_stall--;
      end else tx_ready = ($urandom_range(99) < tx_pct);
      gap_ph   = !gap_ph;
      rx_valid = (rx_q.size() > 0) && !(rx_gap && gap_ph);
      rx_data  = rx_valid ? rx_q[0] : 8'h00;

      if (tx_stalled && tx_valid) chk("tx_hold", tx_data, last_tx);
      tx_stalled = tx_valid && !tx_ready;
      last_tx    = tx_data;

      if (mem_req && mem_ready) begin
        req_wait = 0;
        n_tests++;
        if (exp_mem.size() == 0) begin
          n_fail++;
          $display("FAIL mem_unexp: got access @%0h want none", mem_addr);
        end else begin
          n_tests--;
          e = exp_mem.pop_front();
          chk("mem_we", mem_we, e.we);
          chk("mem_addr", mem_addr, e.addr);
          if (e.we) chk("mem_wdata", mem_wdata, e.data);
        end
        if (mem_we) phys_mem[mem_addr] = mem_wdata;
        else begin
          pend_rd   = 1;
          pend_addr = mem_addr;
          pend_dly  = rd_lat;
        end
      end else if (mem_req) req_wait++;
      else req_wait = 0;

      if (tx_valid && tx_ready) begin
        if (exp_tx.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL tx_unexp: got %0h want none", tx_data);
        end else chk("tx_data", tx_data, exp_tx.pop_front());
      end
      if (rx_valid && rx_ready) void'(rx_q.pop_front());
      if (cmd_valid && cmd_ready) acc_cyc = cyc;

      if (ack_out != 3'b000) begin
        chk("ack_val", ack_out, {1'b1, ID});
        if (exp_ack == 0) begin
          n_tests++; n_fail++;
          $display("FAIL ack_unexp: got %0h want none", ack_out);
        end else exp_ack--;
        if (lat_chk) chk("ack_lat", cyc - acc_cyc, lat_exp);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: expand one command into its whole block of effects
  task automatic model(logic [AW-1:0] a, logic [1:0] rs, logic [1:0] d,
                       logic [1:0] s, logic [1:0] op, int wbase);
    logic [AW-1:0] ad;
    logic [7:0]    b;
    if (rs != 0) return;
    if (op == 2'b01 && s == ID) begin
      for (int i = 0; i < BB; i++) begin
        ad = a + AW'(i);
        exp_mem.push_back('{1'b0, ad, 8'h00});
        exp_tx.push_back(ref_rd(ad));
      end
      exp_ack++;
    end else if (op == 2'b10 && d == ID) begin
      for (int i = 0; i < BB; i++) begin
        ad = a + AW'(i);
        b  = (wbase < 0) ? 8'($urandom) : 8'(wbase + i);
        rx_q.push_back(b);
        exp_mem.push_back('{1'b1, ad, b});
        ref_mem[ad] = b;
      end
      exp_ack++;
    end
  endtask

  task automatic send(logic [AW-1:0] a, logic [1:0] rs, logic [1:0] d,
                      logic [1:0] s, logic [1:0] op, int hold);
    cmd_data  = {a, rs, d, s, op};
    cmd_valid = 1;
    repeat (hold) tick();
    cmd_valid = 0;
    cmd_data  = '0;
  endtask

  task automatic cmd(logic [AW-1:0] a, logic [1:0] rs, logic [1:0] d,
                     logic [1:0] s, logic [1:0] op, int wbase);
    model(a, rs, d, s, op, wbase);
    send(a, rs, d, s, op, 1);
  endtask

  task automatic drain(string nm, int budget);
    int n = 0;
    while ((exp_mem.size() != 0 || exp_tx.size() != 0 ||
            exp_ack > 0 || busy) && n < budget) begin
      tick();
      n++;
    end
    n_tests++;
    if (n >= budget) begin
      n_fail++;
      $display("FAIL %s_timeout: got %0d cycles want <%0d", nm, n, budget);
    end
    tick();
  endtask

  task automatic check_idle(string nm);
    chk({nm, "_cmd_ready"}, cmd_ready, 1);
    chk({nm, "_busy"}, busy, 0);
    chk({nm, "_ack"}, ack_out, 0);
    chk({nm, "_strobes"}, {mem_req, mem_we, tx_valid, rx_ready}, 0);
    chk({nm, "_data"}, {mem_addr, mem_wdata, tx_data}, 0);
  endtask

  task automatic knobs(int ml, int rl, int tp, bit gap);
    mem_lat = ml; rd_lat = rl; tx_pct = tp; rx_gap = gap;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1);
  end

  initial begin
    logic [AW-1:0] ra;
    logic [1:0]    op, s, d, rs;

    rst_n = 0;
    repeat (3) tick();
    check_idle("rst");
    rst_n = 1;
    tick();

    // Zero-wait read with latency check
    knobs(0, 0, 100, 0);
    lat_chk = 1; lat_exp = 3 * BB + 1;
    cmd(24'h000100, 2'b00, 2'b01, 2'b00, 2'b01, 0);
    drain("rd", 2000);

    // Zero-wait write with latency check
    lat_exp = 2 * BB + 1;
    cmd(24'h000300, 2'b00, 2'b00, 2'b01, 2'b10, -1);
    drain("wr0", 2000);
    lat_chk = 0;

    // Write with gapped rx and delayed memory accept
    knobs(2, 0, 100, 1);
    cmd(24'h000200, 2'b00, 2'b00, 2'b01, 2'b10, 8'hA0);
    drain("wr", 3000);

    // Address wrap
    knobs(0, 0, 100, 0);
    cmd(24'hFFFFF0, 2'b00, 2'b01, 2'b00, 2'b01, 0);
    drain("wrap", 2000);

    // Ignored commands
    cmd(24'h000100, 2'b00, 2'b01, 2'b00, 2'b11, 0);
    repeat (3) tick();
    chk("ign_op11", busy, 0);
    cmd(24'h000100, 2'b00, 2'b00, 2'b01, 2'b01, 0);
    repeat (3) tick();
    chk("ign_src", busy, 0);
    cmd(24'h000100, 2'b00, 2'b10, 2'b00, 2'b10, 0);
    repeat (3) tick();
    chk("ign_dst", busy, 0);
    cmd(24'h000100, 2'b01, 2'b00, 2'b00, 2'b01, 0);
    repeat (3) tick();
    chk("ign_rsv", busy, 0);

    // Busy overlap with tx backpressure
    tx_stall = 10;
    cmd(24'h000200, 2'b00, 2'b01, 2'b00, 2'b01, 0);
    repeat (2) tick();
    send(24'h000500, 2'b00, 2'b01, 2'b00, 2'b01, 6);
    drain("ovl", 2000);
    chk("ovl_idle", busy, 0);

    // Reset mid-read
    cmd(24'h000600, 2'b00, 2'b01, 2'b00, 2'b01, 0);
    repeat (20) tick();
    rst_n = 0;
    exp_mem.delete(); exp_tx.delete(); rx_q.delete(); exp_ack = 0;
    repeat (3) tick();
    check_idle("mid_rst");
    rst_n = 1;
    repeat (5) tick();
    chk("post_rst_busy", busy, 0);

    // Randomized commands
    for (int k = 0; k < 14; k++) begin
      knobs($urandom_range(2), $urandom_range(2),
            $urandom_range(100, 30), 1'($urandom_range(1)));
      op = 2'($urandom_range(3));
      s  = ($urandom_range(3) == 0) ? 2'($urandom) : ID;
      d  = ($urandom_range(3) == 0) ? 2'($urandom) : ID;
      rs = ($urandom_range(7) == 0) ? 2'($urandom) : 2'b00;
      case ($urandom_range(3))
        0: ra = 24'h000200;
        1: ra = 24'hFFFFF0 + AW'($urandom_range(15));
        default: ra = AW'($urandom);
      endcase
      cmd(ra, rs, d, s, op, -1);
      drain("rnd", 4000);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
